ifu_fetch_queue: RTL and testbench
==================================

Name: ifu_fetch_queue

Overview:
Parametrised fetch unit that generates its own sequential fetch PCs and requests whole lines from the i-cache interface. It unpacks each returned line into an IQ_DEPTH-entry instruction queue of {pc, instruction, exception} entries, starting at the fetch offset within the line. It sits between the PC/redirect source and instruction decode. Unlike the single-line-register fetch unit, it decouples decode from cache latency, drops stale responses after a flush, and halts on a fetch exception.

Parameters:
XLEN, 64, address/PC width
ILEN, 32, instruction width; instructions are 4-byte aligned
LINE_INSTR, 4, instructions per cache line (power of 2, >=2); line width = LINE_INSTR*ILEN
IQ_DEPTH, 4, instruction queue entries (power of 2, >=2)
BOOT_PC, 0, fetch PC after reset

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
flush_i  in  1  redirect: discard all in-flight state, restart at flush_pc_i
flush_pc_i  in  XLEN  redirect target; bits[1:0] ignored (treated as 0)
read_req_o  out  1  line request valid
read_addr_o  out  XLEN  line-aligned request address (offset bits zero)
read_ready_i  in  1  cache accepts request this cycle
read_done_i  in  1  response valid (one per accepted request, never same cycle as accept)
line_i  in  LINE_INSTR*ILEN  line data, slot k at bits [k*ILEN +: ILEN]
line_exc_i  in  2  0 none, 1 page fault, 2 access fault, 3 reserved (treated as access fault)
issue_valid_o  out  1  queue head valid
issue_ready_i  in  1  decode accepts head
instruction_o  out  ILEN  head instruction
curr_pc_o  out  XLEN  head PC
except_o  out  1  head carries exception
except_code_o  out  4  12 = instr page fault, 1 = instr access fault, 0 otherwise

Behaviour:
- Reset: state IDLE, fetch_pc=BOOT_PC, drop=0, queue empty; read_req_o=0, issue_valid_o=0, all data outputs 0.
- States: IDLE, REQ, WAIT, DRAIN, HALT.
- IDLE -> REQ unconditionally (one cycle after reset release).
- REQ: read_req_o=1, read_addr_o=fetch_pc with low log2(LINE_INSTR)+2 bits cleared; read_req_o=0 in all other states. On read_ready_i -> WAIT.
- WAIT: on read_done_i with drop=1: clear drop, discard, -> REQ. Otherwise capture line_i and line_exc_i, set slot = fetch_pc[log2(LINE_INSTR)+1:2], -> DRAIN.
- DRAIN: push {fetch_pc, line slot, exc} every cycle the queue accepts. After each push fetch_pc += 4 and slot += 1.
  - Exception pushed: instruction field 0, one entry only, -> HALT.
  - Last slot pushed (LINE_INSTR-1): -> REQ; fetch_pc is now the next line base.
- HALT: no requests until flush_i.
- Queue accepts a push when count < IQ_DEPTH, or when full and the head is popped in the same cycle. Pop occurs when issue_valid_o && issue_ready_i.
- Outputs are driven from the registered head; issue_valid_o = count != 0.
- Latency: read_done_i at cycle t -> push at t+1 -> issue_valid_o high at t+2.
- Offset start: fetch_pc at slot s yields LINE_INSTR-s pushes from that line.
- flush_i has priority over every other event in the same cycle:
  - queue emptied (same-cycle pop discarded), fetch_pc <= {flush_pc_i[XLEN-1:2],2'b00}, state <= REQ;
  - drop <= 1 if a response is outstanding: state WAIT without read_done_i this cycle, or state REQ with read_ready_i this cycle;
  - read_done_i coinciding with flush_i is discarded and does not set drop;
  - flush while drop is already 1 and still outstanding keeps drop=1. Only one response is ever outstanding.
- Wrap-around: fetch_pc increments modulo 2^XLEN; queue pointers wrap modulo IQ_DEPTH.
- Asynchronous reset mid-operation returns every state element to its reset value; a later response from the pre-reset request is the integrator's responsibility.

Test Plan:
- Reset, BOOT_PC=0x1000, cache accepts immediately, returns line {0x44,0x33,0x22,0x11} after 3 cycles, decode always ready -> read_addr_o=0x1000; outputs (0x1000,0x11),(0x1004,0x22),(0x1008,0x33),(0x100C,0x44); issue_valid_o first high 2 cycles after read_done_i; next request 0x1010.
- flush_pc_i=0x2008 -> request 0x2000; only (0x2008,slot2),(0x200C,slot3) issued, then request 0x2010.
- issue_ready_i=0 while 4 entries pushed -> queue full, DRAIN stalls, fetch_pc holds. Then ready=1 for 1 cycle -> simultaneous pop+push and count stays 4; no entry lost or duplicated.
- Flush to 0x3000 while WAIT on 0x1000 -> old response discarded with no issue; a new request to 0x3000 is made and only its data appears.
- Flush in the same cycle as read_done_i -> response discarded, drop stays 0, next response accepted.
- line_exc_i=1 on line 0x4000 -> single entry pc=0x4000, except_o=1, except_code_o=12; no further read_req_o until flush. line_exc_i=2 -> except_code_o=1.

Source files
------------

// File: rtl/ifu_fetch_queue_if.sv
// Fetch-unit bus bundle: redirect, i-cache line request/response and decode issue handshake.
// master = fetch unit, slave = surrounding core/cache environment.
interface ifu_fetch_queue_if #(
    parameter int XLEN       = 64,
    parameter int ILEN       = 32,
    parameter int LINE_INSTR = 4
) ();
    logic                       flush_i;
    logic [XLEN-1:0]            flush_pc_i;
    logic                       read_req_o;
    logic [XLEN-1:0]            read_addr_o;
    logic                       read_ready_i;
    logic                       read_done_i;
    logic [LINE_INSTR*ILEN-1:0] line_i;
    logic [1:0]                 line_exc_i;
    logic                       issue_valid_o;
    logic                       issue_ready_i;
    logic [ILEN-1:0]            instruction_o;
    logic [XLEN-1:0]            curr_pc_o;
    logic                       except_o;
    logic [3:0]                 except_code_o;

    modport master (
        input  flush_i, flush_pc_i, read_ready_i, read_done_i, line_i, line_exc_i, issue_ready_i,
        output read_req_o, read_addr_o, issue_valid_o, instruction_o, curr_pc_o, except_o,
               except_code_o
    );

    modport slave (
        output flush_i, flush_pc_i, read_ready_i, read_done_i, line_i, line_exc_i, issue_ready_i,
        input  read_req_o, read_addr_o, issue_valid_o, instruction_o, curr_pc_o, except_o,
               except_code_o
    );
endinterface

// File: rtl/ifu_fetch_queue.sv
// Sequential line fetcher feeding an instruction queue; drops stale responses after a
// redirect and halts after delivering a faulting fetch.
module ifu_fetch_queue #(
    parameter int              XLEN       = 64,
    parameter int              ILEN       = 32,
    parameter int              LINE_INSTR = 4,
    parameter int              IQ_DEPTH   = 4,
    parameter logic [XLEN-1:0] BOOT_PC    = '0
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    ifu_fetch_queue_if.master  bus
);
    localparam int OFF_W    = $clog2(LINE_INSTR);
    localparam int LINE_LSB = OFF_W + 2;
    localparam int PTR_W    = $clog2(IQ_DEPTH);
    localparam int CNT_W    = PTR_W + 1;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, HALT} state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
        logic [1:0]      exc;
    } iq_entry_t;

    state_e                     state_q;
    logic [XLEN-1:0]            fetch_pc_q;
    logic                       drop_q;
    logic [OFF_W-1:0]           slot_q;
    logic [LINE_INSTR*ILEN-1:0] line_q;
    logic [1:0]                 exc_q;
    logic                       read_req_q;
    logic [XLEN-1:0]            read_addr_q;

    iq_entry_t                  iq_q [IQ_DEPTH];
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;

    logic                       pop, push, last_slot, outstanding;
    logic [XLEN-1:0]            flush_pc, next_pc;
    iq_entry_t                  push_entry, head;

    function automatic logic [XLEN-1:0] line_base(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:LINE_LSB], {LINE_LSB{1'b0}}};
    endfunction

    assign flush_pc  = bus.flush_pc_i & ~XLEN'(3);
    assign next_pc   = fetch_pc_q + XLEN'(4);
    assign last_slot = &slot_q;
    assign pop       = (cnt_q != '0) && bus.issue_ready_i;
    assign push      = (state_q == DRAIN) && ((cnt_q != CNT_W'(IQ_DEPTH)) || pop);

    // A response is still owed to us if we are waiting and it has not come back yet,
    // or if the cache takes the request in the very cycle we redirect.
    assign outstanding = ((state_q == WAIT) && !bus.read_done_i) ||
                         ((state_q == REQ) && bus.read_ready_i);

    always_comb begin
        push_entry       = '0;
        push_entry.pc    = fetch_pc_q;
        push_entry.exc   = exc_q;
        push_entry.instr = (exc_q != 2'd0) ? '0 : line_q[int'(slot_q)*ILEN +: ILEN];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            fetch_pc_q  <= BOOT_PC;
            drop_q      <= 1'b0;
            slot_q      <= '0;
            line_q      <= '0;
            exc_q       <= 2'd0;
            read_req_q  <= 1'b0;
            read_addr_q <= '0;
        end else if (bus.flush_i) begin
            state_q     <= REQ;
            fetch_pc_q  <= flush_pc;
            drop_q      <= (drop_q && !bus.read_done_i) || outstanding;
            read_req_q  <= 1'b1;
            read_addr_q <= line_base(flush_pc);
        end else begin
            // The stale response may land while we are already re-requesting.
            if (bus.read_done_i && drop_q) drop_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    state_q     <= REQ;
                    read_req_q  <= 1'b1;
                    read_addr_q <= line_base(fetch_pc_q);
                end
                REQ: begin
                    if (bus.read_ready_i) begin
                        state_q     <= WAIT;
                        read_req_q  <= 1'b0;
                        read_addr_q <= '0;
                    end
                end
                WAIT: begin
                    if (bus.read_done_i) begin
                        if (drop_q) begin
                            state_q     <= REQ;
                            read_req_q  <= 1'b1;
                            read_addr_q <= line_base(fetch_pc_q);
                        end else begin
                            state_q <= DRAIN;
                            line_q  <= bus.line_i;
                            exc_q   <= bus.line_exc_i;
                            slot_q  <= fetch_pc_q[LINE_LSB-1:2];
                        end
                    end
                end
                DRAIN: begin
                    if (push) begin
                        fetch_pc_q <= next_pc;
                        slot_q     <= slot_q + OFF_W'(1);
                        if (exc_q != 2'd0) begin
                            state_q <= HALT;
                        end else if (last_slot) begin
                            state_q     <= REQ;
                            read_req_q  <= 1'b1;
                            read_addr_q <= line_base(next_pc);
                        end
                    end
                end
                HALT: ;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (bus.flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < IQ_DEPTH; i++) iq_q[i] <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            if (push && !bus.flush_i) iq_q[wr_ptr_q] <= push_entry;
        end
    end

    assign head              = iq_q[rd_ptr_q];
    assign bus.read_req_o    = read_req_q;
    assign bus.read_addr_o   = read_addr_q;
    assign bus.issue_valid_o = (cnt_q != '0);
    assign bus.instruction_o = head.instr;
    assign bus.curr_pc_o     = head.pc;
    assign bus.except_o      = (head.exc != 2'd0);
    assign bus.except_code_o = (head.exc == 2'd0) ? 4'd0 : (head.exc == 2'd1) ? 4'd12 : 4'd1;
endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Bench for ifu_fetch_queue: randomized cache/decode timing with an address-derived line
// model and an in-order PC stream scoreboard that restarts on every redirect.
module tb_ifu_fetch_queue;
    localparam int          XLEN = 64;
    localparam int          ILEN = 32;
    localparam int          LI   = 4;
    localparam logic [63:0] BOOT = 64'h1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ifu_fetch_queue_if #(.XLEN(XLEN), .ILEN(ILEN), .LINE_INSTR(LI)) bus ();

    ifu_fetch_queue #(.XLEN(XLEN), .ILEN(ILEN), .LINE_INSTR(LI), .IQ_DEPTH(4), .BOOT_PC(BOOT)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus.master)
    );

    int n_chk = 0, n_pass = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Line contents are a pure function of address so misplaced or stale data is visible.
    function automatic logic [31:0] instr_of(input logic [63:0] pc);
        if (pc >= 64'h1000 && pc < 64'h1010) return 32'h11 * (32'(pc[3:2]) + 32'd1);
        return (pc[31:0] * 32'h9E3779B1) ^ pc[63:32] ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [1:0] exc_of(input logic [63:0] pc);
        case (pc[15:12])
            4'h4:    return 2'd1;
            4'h5:    return 2'd2;
            4'h6:    return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] code_of(input logic [1:0] e);
        return (e == 2'd0) ? 4'd0 : (e == 2'd1) ? 4'd12 : 4'd1;
    endfunction

    // cache model: one outstanding request, random accept and latency
    int          ready_pct = 100, lat_min = 3, lat_max = 3, dec_pct = 100;
    bit          outstanding = 0;
    int          lat_cnt = 0, acc_cnt = 0;
    logic [63:0] req_addr = '0;

    initial begin
        bit          acc;
        logic [63:0] acc_addr;
        bus.read_ready_i = 1'b0;
        bus.read_done_i  = 1'b0;
        bus.line_i       = '0;
        bus.line_exc_i   = 2'd0;
        forever begin
            @(negedge clk);
            acc      = rst_n && bus.read_req_o && bus.read_ready_i;
            acc_addr = bus.read_addr_o;
            @(posedge clk);
            #1;
            bus.read_done_i = 1'b0;
            if (!rst_n) begin
                outstanding = 0;
            end else if (acc) begin
                outstanding = 1;
                acc_cnt++;
                lat_cnt  = $urandom_range(lat_max, lat_min);
                req_addr = acc_addr;
            end else if (outstanding) begin
                if (lat_cnt <= 1) begin
                    bus.read_done_i = 1'b1;
                    outstanding     = 0;
                    for (int k = 0; k < LI; k++)
                        bus.line_i[k*ILEN +: ILEN] = instr_of(req_addr + 64'(4 * k));
                    bus.line_exc_i = exc_of(req_addr);
                end else begin
                    lat_cnt--;
                end
            end
            bus.read_ready_i = rst_n && !outstanding && !bus.read_done_i &&
                               ($urandom_range(99, 0) < ready_pct);
        end
    end

    initial begin
        bus.issue_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.issue_ready_i = ($urandom_range(99, 0) < dec_pct);
        end
    end

    // scoreboard: expected issue stream is exp_pc, exp_pc+4, ... until a faulting line
    logic        req_q1 = 1'b0;
    logic [63:0] exp_pc = BOOT;
    bit          halted = 0;
    int          pops = 0;
    always @(posedge clk) req_q1 <= bus.read_req_o;

    always @(negedge clk) begin
        logic [1:0] e;
        if (!rst_n) begin
            exp_pc = BOOT;
            halted = 0;
        end else if (bus.flush_i) begin
            exp_pc = bus.flush_pc_i & ~64'h3;
            halted = 0;
        end else if (halted) begin
            chk("halt_req", bus.read_req_o, 0);
            chk("halt_issue", bus.issue_valid_o, 0);
        end else if (bus.issue_valid_o && bus.issue_ready_i) begin
            e = exc_of(exp_pc);
            chk("pc", bus.curr_pc_o, exp_pc);
            chk("instr", bus.instruction_o, (e != 2'd0) ? 64'd0 : 64'(instr_of(exp_pc)));
            chk("except", bus.except_o, (e != 2'd0));
            chk("code", bus.except_code_o, code_of(e));
            pops++;
            if (e != 2'd0) halted = 1;
            exp_pc = exp_pc + 64'd4;
        end
    end

    task automatic do_flush(input logic [63:0] pc);
        @(posedge clk);
        #1;
        bus.flush_i    = 1'b1;
        bus.flush_pc_i = pc;
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        @(negedge clk);
        chk("flush_req", bus.read_req_o, 1);
        chk("flush_addr", bus.read_addr_o, pc & ~64'(4 * LI - 1));
    endtask

    task automatic wait_req_rise(input logic [63:0] exp, input string tag);
        bit seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (bus.read_req_o && !req_q1) seen = 1;
        end
        chk({tag, "_seen"}, seen, 1);
        if (seen) chk(tag, bus.read_addr_o, exp);
    endtask

    task automatic wait_pops(input int n, input string tag);
        int tgt = pops + n;
        bit ok = 0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            if (pops >= tgt) ok = 1;
        end
        chk({tag, "_pops"}, ok, 1);
    endtask

    task automatic wait_halt(input string tag);
        bit ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (halted) ok = 1;
        end
        chk({tag, "_halt"}, ok, 1);
    endtask

    initial begin
        int          t0, p0, base;
        bit          ok;
        logic [63:0] pc;
        bus.flush_i    = 1'b0;
        bus.flush_pc_i = '0;

        repeat (3) @(negedge clk);
        chk("rst_req", bus.read_req_o, 0);
        chk("rst_addr", bus.read_addr_o, 0);
        chk("rst_valid", bus.issue_valid_o, 0);
        chk("rst_instr", bus.instruction_o, 0);
        chk("rst_pc", bus.curr_pc_o, 0);
        chk("rst_exc", bus.except_o, 0);
        chk("rst_code", bus.except_code_o, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // boot line and issue latency
        wait_req_rise(BOOT, "boot_req");
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.read_done_i) ok = 1;
        end
        chk("boot_done_seen", ok, 1);
        t0 = cyc;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (bus.issue_valid_o) ok = 1;
            else @(negedge clk);
        end
        chk("boot_valid_seen", ok, 1);
        chk("boot_latency", 64'(cyc - t0), 2);
        wait_req_rise(64'h1010, "next_req");

        // offset start within a line
        do_flush(64'h2008);
        wait_req_rise(64'h2010, "offset_next_req");

        // full queue stall, then one simultaneous pop+push
        dec_pct = 0;
        repeat (2) @(negedge clk);
        p0 = pops;
        repeat (38) @(negedge clk);
        chk("full_valid", bus.issue_valid_o, 1);
        chk("full_req", bus.read_req_o, 0);
        chk("full_nopop", 64'(pops - p0), 0);
        dec_pct = 100;
        @(negedge clk);
        dec_pct = 0;
        repeat (10) @(negedge clk);
        chk("full2_valid", bus.issue_valid_o, 1);
        chk("full2_req", bus.read_req_o, 0);
        chk("full2_onepop", 64'(pops - p0), 1);
        dec_pct = 100;
        wait_pops(10, "full_resume");

        // redirect while waiting: old line must never surface
        lat_min = 6; lat_max = 6;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (outstanding && lat_cnt >= 3) ok = 1;
        end
        chk("wait_flush_seen", ok, 1);
        do_flush(64'h3000);
        wait_pops(4, "wait_flush");

        // redirect coincident with response: no drop, single request for new target
        lat_min = 3; lat_max = 3;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (outstanding && lat_cnt == 1) ok = 1;
        end
        chk("done_flush_seen", ok, 1);
        do_flush(64'h7000);
        base = acc_cnt;
        wait_pops(1, "done_flush");
        chk("done_flush_accepts", 64'(acc_cnt - base), 1);

        // fetch exceptions halt after one entry
        do_flush(64'h4000);
        wait_halt("page_fault");
        repeat (15) @(negedge clk);
        do_flush(64'h5008);
        wait_halt("access_fault");
        do_flush(64'h6004);
        wait_halt("reserved_fault");

        // PC wrap-around
        do_flush(64'hFFFF_FFFF_FFFF_FFF8);
        wait_req_rise(64'h0, "wrap_req");
        wait_pops(6, "wrap");

        // reset mid-operation
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst2_valid", bus.issue_valid_o, 0);
        chk("rst2_req", bus.read_req_o, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_req_rise(BOOT, "rst2_boot_req");

        // randomized timing and redirects
        for (int it = 0; it < 200; it++) begin
            @(negedge clk);
            ready_pct = $urandom_range(100, 30);
            dec_pct   = $urandom_range(100, 10);
            lat_min   = 1;
            lat_max   = $urandom_range(6, 1);
            repeat ($urandom_range(40, 3)) @(negedge clk);
            pc = {$urandom, $urandom};
            if ($urandom_range(3, 0) != 0) pc[63:16] = '0;
            do_flush(pc);
        end

        ready_pct = 100; dec_pct = 100; lat_min = 2; lat_max = 2;
        do_flush(64'h8000);
        wait_pops(8, "final");
        chk("progress", (pops >= 100), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
